// File: rtl/shift_pipe.sv
// shift_pipe: pipelined barrel shifter (SLL/SRL/SRA, optional ROL/ROR) with a global valid/ready stall.
// Ports: m_clock; p_reset (async, active-low);
//        in_valid/in_ready/in_data/in_shamt/in_op form the request side;
//        out_valid/out_ready/out_data/out_err form the result side; out_err=1 flags an illegal or disabled op.
// Define SHIFT_PIPE_ROTATE_EN to enable ROL (op 3) and ROR (op 4); otherwise those ops are illegal.
module shift_pipe #(
    parameter int WIDTH = 32,
    parameter int PIPE = 2,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             m_clock,
    input  logic             p_reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err
);
    logic             adv;
    logic             illegal;
    logic             vld_q  [PIPE];
    logic             vld_d  [PIPE];
    logic [2:0]       op_q   [PIPE];
    logic [2:0]       op_d   [PIPE];
    logic [SHW-1:0]   sh_q   [PIPE];
    logic [SHW-1:0]   sh_d   [PIPE];
    logic             fill_q [PIPE];
    logic             fill_d [PIPE];
    logic             err_q  [PIPE];
    logic             err_d  [PIPE];
    logic [WIDTH-1:0] pre    [PIPE];
    logic [WIDTH-1:0] dat_d  [PIPE];
    logic [WIDTH-1:0] dat_q  [PIPE];

    // One mux level shifting by sh (a power of two); fill supplies the SRA sign bits.
    function automatic logic [WIDTH-1:0] lvl(input logic [WIDTH-1:0] x, input logic [2:0] op,
                                             input logic fill, input int sh);
        logic [WIDTH-1:0] hi;
        hi = fill ? ~({WIDTH{1'b1}} >> sh) : '0;
`ifdef SHIFT_PIPE_ROTATE_EN
        lvl = op == 3'd0 ? x << sh :
              op == 3'd3 ? (x << sh) | (x >> (WIDTH - sh)) :
              op == 3'd4 ? (x >> sh) | (x << (WIDTH - sh)) :
              (x >> sh) | hi;
`else
        lvl = op == 3'd0 ? x << sh : (x >> sh) | hi;
`endif
    endfunction

`ifdef SHIFT_PIPE_ROTATE_EN
    assign illegal = in_op > 3'd4;
`else
    assign illegal = in_op > 3'd2;
`endif

    assign adv       = !vld_q[PIPE-1] || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_q[PIPE-1];
    assign out_data  = dat_q[PIPE-1];
    assign out_err   = err_q[PIPE-1];

    // Illegal ops enter as zero data with no fill, so every level keeps them zero.
    always_comb begin
        vld_d[0]  = in_valid;
        op_d[0]   = in_op;
        sh_d[0]   = in_shamt;
        err_d[0]  = illegal;
        fill_d[0] = in_op == 3'd2 && in_data[WIDTH-1];
        pre[0]    = illegal ? '0 : in_data;
        for (int s = 1; s < PIPE; s++) begin
            vld_d[s]  = vld_q[s-1];
            op_d[s]   = op_q[s-1];
            sh_d[s]   = sh_q[s-1];
            err_d[s]  = err_q[s-1];
            fill_d[s] = fill_q[s-1];
            pre[s]    = dat_q[s-1];
        end
        // Level k lives in front of stage floor(k*PIPE/SHW).
        for (int s = 0; s < PIPE; s++) begin
            dat_d[s] = pre[s];
            for (int k = 0; k < SHW; k++)
                if ((k * PIPE) / SHW == s && |(sh_d[s] & SHW'(1 << k)))
                    dat_d[s] = lvl(dat_d[s], op_d[s], fill_d[s], 1 << k);
        end
    end

    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            for (int s = 0; s < PIPE; s++) begin
                vld_q[s]  <= 1'b0;
                op_q[s]   <= '0;
                sh_q[s]   <= '0;
                fill_q[s] <= 1'b0;
                err_q[s]  <= 1'b0;
                dat_q[s]  <= '0;
            end
        end else if (adv) begin
            for (int s = 0; s < PIPE; s++) begin
                vld_q[s]  <= vld_d[s];
                op_q[s]   <= op_d[s];
                sh_q[s]   <= sh_d[s];
                fill_q[s] <= fill_d[s];
                err_q[s]  <= err_d[s];
                dat_q[s]  <= dat_d[s];
            end
        end
    end
endmodule

// File: tb/tb_shift_pipe.sv
// tb_shift_pipe: directed and scoreboard checks of shift_pipe (WIDTH=32, PIPE=2).
module tb_shift_pipe;
    localparam int PIPE = 2;

    logic        m_clock = 1'b0;
    logic        p_reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_shamt;
    logic [2:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_err;

    int n_chk = 0;
    int n_bad = 0;
    logic [32:0] got_q[$];
    logic [32:0] exp_q[$];

    shift_pipe #(.WIDTH(32), .PIPE(PIPE)) dut (
        .m_clock(m_clock), .p_reset(p_reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_shamt(in_shamt), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_err(out_err)
    );

    always #5 m_clock = ~m_clock;

    // Inputs change only at posedge+1, so a negedge sample sees what the next posedge will use.
    always @(negedge m_clock)
        if (p_reset && out_valid && out_ready) got_q.push_back({out_err, out_data});

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [32:0] model(input logic [2:0] op, input logic [31:0] d, input logic [4:0] s);
        case (op)
            3'd0: return {1'b0, d << s};
            3'd1: return {1'b0, d >> s};
            3'd2: return {1'b0, 32'($signed(d) >>> s)};
`ifdef SHIFT_PIPE_ROTATE_EN
            3'd3: return {1'b0, (d << s) | (d >> (6'd32 - {1'b0, s}))};
            3'd4: return {1'b0, (d >> s) | (d << (6'd32 - {1'b0, s}))};
`endif
            default: return {1'b1, 32'h0};
        endcase
    endfunction

    // Starts and ends at posedge+1; returns just after the accepting edge.
    task automatic send(input logic [2:0] op, input logic [31:0] d, input logic [4:0] s);
        int n = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_data  = d;
        in_shamt = s;
        do begin
            @(negedge m_clock);
            n++;
        end while (!in_ready && n < 200);
        if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'd1);
        exp_q.push_back(model(op, d, s));
        @(posedge m_clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run1(input string tag, input logic [2:0] op, input logic [31:0] d,
                        input logic [4:0] s, input logic [31:0] ed, input logic ee);
        int n = 0;
        logic [32:0] r;
        send(op, d, s);
        while (got_q.size() == 0 && n < 50) begin
            @(negedge m_clock);
            #1;
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'(PIPE));
        r = got_q.size() > 0 ? got_q.pop_front() : 33'h1_dead_beef;
        chk({tag, "_dat"}, 64'(r[31:0]), 64'(ed));
        chk({tag, "_err"}, 64'(r[32]), 64'(ee));
        exp_q.delete();
        @(posedge m_clock);
        #1;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (got_q.size() < exp_q.size() && n < 500) begin
            @(negedge m_clock);
            #1;
            n++;
        end
        repeat (PIPE + 3) @(negedge m_clock);
        #1;
        chk({tag, "_cnt"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk({tag, "_res"}, 64'(got_q[i]), 64'(exp_q[i]));
        @(posedge m_clock);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // T1 reset with a request pending
        p_reset   = 1'b0;
        in_valid  = 1'b1;
        in_op     = 3'd0;
        in_data   = 32'h5;
        in_shamt  = 5'd1;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge m_clock);
            chk("rst_vld", 64'(out_valid), 64'd0);
            chk("rst_dat", 64'(out_data), 64'd0);
        end
        @(posedge m_clock);
        #1;
        p_reset  = 1'b1;
        in_valid = 1'b0;
        @(negedge m_clock);
        chk("rst_rdy", 64'(in_ready), 64'd1);
        @(posedge m_clock);
        #1;

        // T2 basic
        run1("sll", 3'd0, 32'h0000_00F1, 5'd4, 32'h0000_0F10, 1'b0);
        run1("sra", 3'd2, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0);
        run1("srl", 3'd1, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0);
        run1("sra_pos", 3'd2, 32'h4000_0000, 5'd30, 32'h0000_0001, 1'b0);

        // T3 rotates
`ifdef SHIFT_PIPE_ROTATE_EN
        run1("ror", 3'd4, 32'h0000_0001, 5'd1, 32'h8000_0000, 1'b0);
        run1("rol", 3'd3, 32'h8000_0001, 5'd4, 32'h0000_0018, 1'b0);
`else
        run1("ror", 3'd4, 32'h0000_0001, 5'd1, 32'h0, 1'b1);
        run1("rol", 3'd3, 32'h8000_0001, 5'd4, 32'h0, 1'b1);
`endif

        // T4 back-pressure
        fork
            begin
                for (int i = 1; i <= 8; i++) send(3'd0, 32'(i), 5'd1);
            end
            begin
                logic [31:0] held;
                repeat (3) @(posedge m_clock);
                #1;
                out_ready = 1'b0;
                @(negedge m_clock);
                held = out_data;
                chk("stall_vld", 64'(out_valid), 64'd1);
                chk("stall_rdy", 64'(in_ready), 64'd0);
                repeat (4) begin
                    @(negedge m_clock);
                    chk("stall_hold", 64'(out_data), 64'(held));
                    chk("stall_rdy", 64'(in_ready), 64'd0);
                end
                @(posedge m_clock);
                #1;
                out_ready = 1'b1;
            end
        join
        drain("bp");
        for (int i = 0; i < got_q.size(); i++)
            chk("bp_order", 64'(got_q[i]), 64'(2 * (i + 1)));
        got_q.delete();
        exp_q.delete();

        // T5 boundaries
        run1("z_sll", 3'd0, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1'b0);
        run1("z_srl", 3'd1, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1'b0);
        run1("z_sra", 3'd2, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1'b0);
`ifdef SHIFT_PIPE_ROTATE_EN
        run1("z_rol", 3'd3, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1'b0);
        run1("z_ror", 3'd4, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1'b0);
`endif
        run1("op7", 3'd7, 32'hFFFF_FFFF, 5'd3, 32'h0, 1'b1);
        run1("op5", 3'd5, 32'h1234_5678, 5'd0, 32'h0, 1'b1);
        for (int i = 0; i < 100; i++)
            send(3'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 31)));
        drain("rand");
        got_q.delete();
        exp_q.delete();

        // T6 reset mid-flight
        send(3'd0, 32'h1, 5'd1);
        send(3'd0, 32'h2, 5'd1);
        p_reset = 1'b0;
        got_q.delete();
        exp_q.delete();
        @(posedge m_clock);
        #1;
        p_reset = 1'b1;
        repeat (5) begin
            @(negedge m_clock);
            chk("flush_vld", 64'(out_valid), 64'd0);
        end
        @(posedge m_clock);
        #1;
        chk("flush_cnt", 64'(got_q.size()), 64'd0);
        run1("post_rst", 3'd1, 32'hF000_0000, 5'd4, 32'h0F00_0000, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
